// File: rtl/tl_ns_logic.sv
// tl_ns_logic
// Next-state logic and state register for an eight-state, two-street traffic
// light controller. The phases run in a fixed ring, and each street has a
// protected left-turn phase:
//   A green -> A yellow -> A left green -> A left yellow ->
//   B green -> B yellow -> B left green -> B left yellow -> (A green)
// A green phase holds while its own sensor reports traffic. Every yellow
// phase advances unconditionally after one clock.
//
// Ports:
//   clk        rising-edge clock for the state register
//   reset      asynchronous, active-high; forces state to S0 (3'b000)
//   Ta, Tal    street A straight / left-turn traffic present
//   Tb, Tbl    street B straight / left-turn traffic present
//   q2..q0     current registered state (q2 = MSB)
//   d2..d0     combinational next state (d2 = MSB)
module tl_ns_logic (
  input  logic clk,
  input  logic reset,
  input  logic Ta,
  input  logic Tal,
  input  logic Tb,
  input  logic Tbl,
  output logic q2,
  output logic q1,
  output logic q0,
  output logic d2,
  output logic d1,
  output logic d0
);

  typedef enum logic [2:0] {
    S0 = 3'b000,  // A green
    S1 = 3'b001,  // A yellow
    S2 = 3'b010,  // A left green
    S3 = 3'b011,  // A left yellow
    S4 = 3'b100,  // B green
    S5 = 3'b101,  // B yellow
    S6 = 3'b110,  // B left green
    S7 = 3'b111   // B left yellow
  } state_e;

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the sensor that belongs to the current green phase is examined.
  // All other sensors are ignored in that state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S0: state_d = Ta  ? S0 : S1;
      S1: state_d = S2;
      S2: state_d = Tal ? S2 : S3;
      S3: state_d = S4;
      S4: state_d = Tb  ? S4 : S5;
      S5: state_d = S6;
      S6: state_d = Tbl ? S6 : S7;
      S7: state_d = S0;
    endcase
  end

  assign {q2, q1, q0} = state_q;
  assign {d2, d1, d0} = state_d;

endmodule

// File: tb/tb_tl_ns_logic.sv
// Self-checking bench for tl_ns_logic: directed vector table, hand-written
// reset and free-run sequences, and randomized sensors checked against a
// phase-ring model.
module tb_tl_ns_logic;

  logic clk;
  logic reset;
  logic Ta, Tal, Tb, Tbl;
  logic q2, q1, q0, d2, d1, d0;

  int unsigned checks;
  int unsigned errors;

  tl_ns_logic dut (
    .clk   (clk),
    .reset (reset),
    .Ta    (Ta),
    .Tal   (Tal),
    .Tb    (Tb),
    .Tbl   (Tbl),
    .q2    (q2),
    .q1    (q1),
    .q0    (q0),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       rst;
    logic [3:0] sens;   // {Ta, Tal, Tb, Tbl}
    logic [2:0] exp_q;
    logic [2:0] exp_d;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] sens);
    reset = rst;
    {Ta, Tal, Tb, Tbl} = sens;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the eight phases form a ring. Phase s is "green" when even;
  // green phase s watches sensor number s/2 in the order Ta, Tal, Tb, Tbl.
  function automatic int unsigned model_next(input int unsigned s, input logic [3:0] sens);
    int unsigned sensor_idx;
    sensor_idx = s / 2;
    if ((s % 2 == 0) && sens[3 - sensor_idx]) return s;
    return (s + 1) % 8;
  endfunction

  initial begin
    logic [2:0] q_now;
    logic [2:0] d_now;
    int unsigned m;
    logic rst_r;
    logic [3:0] sens_r;

    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b1, 4'b1000, 3'b000, 3'b000};
    vecs[1]  = '{1'b0, 4'b1000, 3'b000, 3'b000};
    vecs[2]  = '{1'b0, 4'b1000, 3'b000, 3'b000};
    vecs[3]  = '{1'b0, 4'b1000, 3'b000, 3'b000};
    vecs[4]  = '{1'b0, 4'b1010, 3'b000, 3'b000};
    vecs[5]  = '{1'b0, 4'b0100, 3'b000, 3'b001};
    vecs[6]  = '{1'b0, 4'b1111, 3'b001, 3'b010};
    vecs[7]  = '{1'b0, 4'b0110, 3'b010, 3'b010};
    vecs[8]  = '{1'b0, 4'b0010, 3'b010, 3'b011};
    vecs[9]  = '{1'b0, 4'b0000, 3'b011, 3'b100};
    vecs[10] = '{1'b0, 4'b0010, 3'b100, 3'b100};
    vecs[11] = '{1'b0, 4'b0001, 3'b100, 3'b101};
    vecs[12] = '{1'b0, 4'b1111, 3'b101, 3'b110};
    vecs[13] = '{1'b0, 4'b1111, 3'b110, 3'b110};
    vecs[14] = '{1'b0, 4'b0101, 3'b110, 3'b110};
    vecs[15] = '{1'b0, 4'b1000, 3'b110, 3'b111};
    vecs[16] = '{1'b0, 4'b1111, 3'b111, 3'b000};
    vecs[17] = '{1'b0, 4'b0000, 3'b000, 3'b001};

    drive(1'b1, 4'b0000);
    #2;
    chk("reset_async_q", {q2, q1, q0}, 3'b000);
    tick();

    // Directed table: each row is checked, then one clock edge is applied.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].sens);
      #1;
      chk($sformatf("vec%0d_q", i), {q2, q1, q0}, vecs[i].exp_q);
      chk($sformatf("vec%0d_d", i), {d2, d1, d0}, vecs[i].exp_d);
      tick();
    end

    // Free run with all sensors low from reset: full ring in 8 clocks.
    drive(1'b1, 4'b0000);
    tick();
    drive(1'b0, 4'b0000);
    #1;
    chk("free_q_start", {q2, q1, q0}, 3'b000);
    for (int i = 1; i <= 8; i++) begin
      tick();
      q_now = 3'(i % 8);
      chk($sformatf("free_q_step%0d", i), {q2, q1, q0}, q_now);
    end

    // Run to S5, then assert reset between edges.
    for (int i = 0; i < 5; i++) tick();
    chk("midrun_at_s5", {q2, q1, q0}, 3'b101);
    #2;
    reset = 1'b1;
    #1;
    chk("midrun_async_reset_q", {q2, q1, q0}, 3'b000);
    chk("midrun_async_reset_d", {d2, d1, d0}, 3'b001);
    tick();
    reset = 1'b0;
    #1;
    chk("midrun_release_q", {q2, q1, q0}, 3'b000);
    tick();
    chk("midrun_resume_s1", {q2, q1, q0}, 3'b001);
    tick();
    chk("midrun_resume_s2", {q2, q1, q0}, 3'b010);

    // Randomized sensors and occasional reset against the ring model.
    drive(1'b1, 4'b0000);
    tick();
    m = 0;
    for (int i = 0; i < 400; i++) begin
      rst_r  = ($urandom_range(0, 31) == 0);
      sens_r = 4'($urandom_range(0, 15));
      drive(rst_r, sens_r);
      #1;
      if (rst_r) m = 0;
      q_now = 3'(m);
      d_now = 3'(model_next(m, sens_r));
      chk($sformatf("rand%0d_q", i), {q2, q1, q0}, q_now);
      chk($sformatf("rand%0d_d", i), {d2, d1, d0}, d_now);
      tick();
      m = rst_r ? 0 : model_next(m, sens_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
